// File: rtl/l2_pkg.sv
// Shared types for the L2 request arbiter.
//   L1_reqid_type .. SC_sptbr_type : request field types
//   L2_arb_req_type                : packed bundle of the five forwarded fields
//   l2_src_e                       : source port index carried with a grant
//   rr_pick_dc                     : round-robin grant decision for port 1
package l2_pkg;

  localparam int QDEPTH_DEFAULT = 2;

  typedef logic [4:0]  L1_reqid_type;
  typedef logic [2:0]  SC_cmd_type;
  typedef logic [12:0] SC_pcsign_type;
  typedef logic [38:0] SC_laddr_type;
  typedef logic [37:0] SC_sptbr_type;

  typedef struct packed {
    L1_reqid_type  dcid;
    SC_cmd_type    cmd;
    SC_pcsign_type pcsign;
    SC_laddr_type  laddr;
    SC_sptbr_type  sptbr;
  } L2_arb_req_type;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } l2_src_e;

  // Port 1 wins when it is the only non-empty queue, or when both are
  // non-empty and the priority pointer is 0 (ptr=1 favours port 0).
  function automatic logic rr_pick_dc(input logic ic_ne, input logic dc_ne,
                                      input logic ptr);
    return dc_ne & (~ic_ne | ~ptr);
  endfunction

endpackage

// File: rtl/l2cache_req_arb_if.sv
// Request channel between a cache and the arbiter, and between the arbiter
// and the L2 pipe.
//   valid : request present          (sender -> receiver)
//   retry : receiver refuses         (receiver -> sender)
//   src   : originating port index   (only meaningful toward the L2 pipe)
//   req   : packed request fields
// Handshake: a transfer happens on a rising clock edge where valid=1 and
// retry=0. While retry=1 the sender keeps valid and req unchanged.
interface l2cache_req_arb_if;
  import l2_pkg::*;

  logic           valid;
  logic           retry;
  logic           src;
  L2_arb_req_type req;

  modport master (output valid, output src, output req, input retry);
  modport slave  (input valid, input req, output retry);

endinterface

// File: rtl/l2_req_fifo2.sv
// Two-entry request FIFO used as the per-port input queue.
//   clk, reset : clock, synchronous active-high reset (empties the queue)
//   push_i     : write data_i (ignored when full)
//   data_i     : request to enqueue
//   pop_i      : drop the head (ignored when empty)
//   data_o     : current head
//   full_o     : count == DEPTH (registered)
//   empty_o    : count == 0 (registered)
module l2_req_fifo2
  import l2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push_i,
  input  L2_arb_req_type data_i,
  input  logic           pop_i,
  output L2_arb_req_type data_o,
  output logic           full_o,
  output logic           empty_o
);

  L2_arb_req_type mem_q [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == 2'(DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    // push and pop together leave the occupancy unchanged
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2cache_req_arb.sv
// Two-port round-robin arbiter feeding the L2 pipe request port.
//   clk, reset : clock, synchronous active-high reset
//   ic_req     : icache requests (port 0), slave side
//   dc_req     : dcache requests (port 1), slave side
//   l2_req     : registered request toward the L2 pipe, master side;
//                l2_req.src names the port that won the grant
// Each port has a 2-entry queue whose full flag is the port's retry. The
// arbiter looks at the queue heads and refills the output register whenever
// it is empty or is transferring this cycle, so a saturated L2 sees one
// request per cycle. Latency from input transfer to l2_req.valid is 2 cycles.
module l2cache_req_arb
  import l2_pkg::*;
#(
  parameter int QDEPTH    = QDEPTH_DEFAULT,
  parameter bit RESET_PTR = 1'b1
) (
  input logic clk,
  input logic reset,
  l2cache_req_arb_if.slave  ic_req,
  l2cache_req_arb_if.slave  dc_req,
  l2cache_req_arb_if.master l2_req
);

  L2_arb_req_type ic_head, dc_head;
  logic           ic_full, ic_empty, dc_full, dc_empty;
  logic           ic_push, dc_push;
  logic           grant_ic, grant_dc;
  logic           stage_free;

  logic           out_valid_q, out_valid_d;
  logic           out_src_q, out_src_d;
  L2_arb_req_type out_req_q, out_req_d;
  logic           rr_ptr_q, rr_ptr_d;

  // Retry comes straight from the registered full flag.
  assign ic_req.retry = ic_full;
  assign dc_req.retry = dc_full;
  assign ic_push      = ic_req.valid & ~ic_full;
  assign dc_push      = dc_req.valid & ~dc_full;

  l2_req_fifo2 #(.DEPTH(QDEPTH)) u_ic_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ic_push),
    .data_i  (ic_req.req),
    .pop_i   (grant_ic),
    .data_o  (ic_head),
    .full_o  (ic_full),
    .empty_o (ic_empty)
  );

  l2_req_fifo2 #(.DEPTH(QDEPTH)) u_dc_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (dc_push),
    .data_i  (dc_req.req),
    .pop_i   (grant_dc),
    .data_o  (dc_head),
    .full_o  (dc_full),
    .empty_o (dc_empty)
  );

  // The output register may be overwritten when empty or when its current
  // contents leave this cycle.
  assign stage_free = ~out_valid_q | ~l2_req.retry;

  always_comb begin
    grant_ic    = 1'b0;
    grant_dc    = 1'b0;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_req_d   = out_req_q;
    rr_ptr_d    = rr_ptr_q;
    if (stage_free) begin
      grant_dc    = rr_pick_dc(~ic_empty, ~dc_empty, rr_ptr_q);
      grant_ic    = ~ic_empty & ~grant_dc;
      out_valid_d = grant_ic | grant_dc;
      if (grant_ic) begin
        out_src_d = SRC_IC;
        out_req_d = ic_head;
      end
      if (grant_dc) begin
        out_src_d = SRC_DC;
        out_req_d = dc_head;
      end
      // Only a contested grant moves priority, and it moves to the loser.
      if (!ic_empty && !dc_empty) rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_src_q   <= SRC_IC;
      out_req_q   <= '0;
      rr_ptr_q    <= RESET_PTR;
    end else begin
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_req_q   <= out_req_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign l2_req.valid = out_valid_q;
  assign l2_req.src   = out_src_q;
  assign l2_req.req   = out_req_q;

endmodule

// File: tb/tb_l2cache_req_arb.sv
// Bench for l2cache_req_arb: directed scenarios plus random traffic, checked
// against a transaction-level model made of per-port queues, one staged slot
// and a priority bit.
module tb_l2cache_req_arb;
  import l2_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2cache_req_arb_if ic_if ();
  l2cache_req_arb_if dc_if ();
  l2cache_req_arb_if l2_if ();

  l2cache_req_arb #(.QDEPTH(2), .RESET_PTR(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .ic_req (ic_if),
    .dc_req (dc_if),
    .l2_req (l2_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  L2_arb_req_type m_ic[$];
  L2_arb_req_type m_dc[$];
  logic           m_v   = 1'b0;
  logic           m_src = 1'b0;
  logic           m_ptr = 1'b1;
  L2_arb_req_type m_req = '0;
  bit             ic_pend = 0, dc_pend = 0;
  int             acc_ic = 0, acc_dc = 0;
  logic [97:0]    exp_q[$];

  function automatic L2_arb_req_type rand_req();
    L2_arb_req_type r;
    r.dcid   = 5'($urandom);
    r.cmd    = 3'($urandom);
    r.pcsign = 13'($urandom);
    r.laddr  = {7'($urandom), 32'($urandom)};
    r.sptbr  = {6'($urandom), 32'($urandom)};
    return r;
  endfunction

  // Applies one clock edge worth of the arbiter rules to the model.
  task automatic model_update();
    bit ic_acc, dc_acc, ic_ne, dc_ne;
    if (reset) begin
      m_ic.delete(); m_dc.delete();
      m_v = 1'b0; m_src = 1'b0; m_req = '0; m_ptr = 1'b1;
      ic_pend = 0; dc_pend = 0;
      return;
    end
    ic_acc = ic_if.valid && (m_ic.size() < 2);
    dc_acc = dc_if.valid && (m_dc.size() < 2);
    ic_ne  = m_ic.size() != 0;
    dc_ne  = m_dc.size() != 0;
    if (!m_v || !l2_if.retry) begin
      if (ic_ne && (!dc_ne || m_ptr)) begin
        m_req = m_ic.pop_front(); m_src = 1'b0; m_v = 1'b1;
        if (dc_ne) m_ptr = 1'b0;
      end else if (dc_ne) begin
        m_req = m_dc.pop_front(); m_src = 1'b1; m_v = 1'b1;
        if (ic_ne) m_ptr = 1'b1;
      end else begin
        m_v = 1'b0;
      end
    end
    if (ic_acc) begin m_ic.push_back(ic_if.req); acc_ic++; end
    if (dc_acc) begin m_dc.push_back(dc_if.req); acc_dc++; end
    ic_pend = ic_if.valid && !ic_acc;
    dc_pend = dc_if.valid && !dc_acc;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- driver ----------------
  // A refused request stays on the bus unchanged; otherwise a new one may start.
  task automatic drive(input bit want_ic, input bit want_dc);
    if (!ic_pend) begin
      ic_if.valid = want_ic;
      if (want_ic) ic_if.req = rand_req();
    end
    if (!dc_pend) begin
      dc_if.valid = want_dc;
      if (want_dc) dc_if.req = rand_req();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0);
    step(); step();
    reset = 1'b0;
    checks++;
    if (l2_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", l2_if.valid); end
    checks++;
    if (ic_if.retry !== 1'b0 || dc_if.retry !== 1'b0) begin
      failures++; $display("FAIL reset_retry: got ic=%b dc=%b want 0 0", ic_if.retry, dc_if.retry);
    end
    checks++;
    if (l2_if.src !== 1'b0) begin failures++; $display("FAIL reset_src: got %b want 0", l2_if.src); end
    checks++;
    if (l2_if.req !== 98'd0) begin failures++; $display("FAIL reset_data: got %h want 0", l2_if.req); end
  endtask

  task automatic test_single();
    L2_arb_req_type sent;
    step(); step();
    sent       = rand_req();
    sent.dcid  = 5'd3;
    sent.laddr = 39'h12345;
    ic_if.valid = 1'b1;
    ic_if.req   = sent;
    step();                       // input transfer on this edge
    ic_if.valid = 1'b0;
    checks++;
    if (l2_if.valid !== 1'b0) begin failures++; $display("FAIL single_n1: got valid=%b want 0", l2_if.valid); end
    step();
    checks++;
    if (l2_if.valid !== 1'b1 || l2_if.src !== 1'b0 || l2_if.req !== sent) begin
      failures++;
      $display("FAIL single_n2: got v=%b src=%b req=%h want v=1 src=0 req=%h", l2_if.valid, l2_if.src, l2_if.req, sent);
    end
    step();
    checks++;
    if (l2_if.valid !== 1'b0 || ic_if.retry !== 1'b0) begin
      failures++; $display("FAIL single_n3: got v=%b retry=%b want 0 0", l2_if.valid, ic_if.retry);
    end
  endtask

  task automatic test_saturate();
    bit   started = 0;
    logic exp_alt = 1'b0;
    l2_if.retry = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1, 1);
      step();
      checks++;
      if (l2_if.valid !== m_v || ic_if.retry !== (m_ic.size() == 2) || dc_if.retry !== (m_dc.size() == 2)) begin
        failures++;
        $display("FAIL sat_ctrl k=%0d: got v=%b icr=%b dcr=%b want v=%b icr=%b dcr=%b", k, l2_if.valid,
                 ic_if.retry, dc_if.retry, m_v, m_ic.size() == 2, m_dc.size() == 2);
      end
      if (m_v) begin
        checks++;
        if (l2_if.src !== m_src || l2_if.req !== m_req) begin
          failures++;
          $display("FAIL sat_data k=%0d: got src=%b req=%h want src=%b req=%h", k, l2_if.src, l2_if.req, m_src, m_req);
        end
        if (started) begin
          exp_alt = ~exp_alt;
          checks++;
          if (l2_if.src !== exp_alt) begin
            failures++; $display("FAIL sat_alternate k=%0d: got src=%b want %b", k, l2_if.src, exp_alt);
          end
        end else begin
          started = 1;
          exp_alt = m_src;
        end
      end
    end
  endtask

  task automatic test_stall();
    L2_arb_req_type held = '0;
    bit have_held = 0;
    l2_if.retry = 1'b0;
    for (int k = 0; k < 8; k++) begin drive(0, 0); step(); end
    l2_if.retry = 1'b1;
    acc_ic = 0; acc_dc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1);
      step();
      if (m_v) begin
        if (!have_held) begin held = m_req; have_held = 1; end
        checks++;
        if (l2_if.valid !== 1'b1 || l2_if.req !== held) begin
          failures++;
          $display("FAIL stall_stable k=%0d: got v=%b req=%h want v=1 req=%h", k, l2_if.valid, l2_if.req, held);
        end
      end
    end
    checks++;
    if (ic_if.retry !== 1'b1 || dc_if.retry !== 1'b1) begin
      failures++; $display("FAIL stall_full: got icr=%b dcr=%b want 1 1", ic_if.retry, dc_if.retry);
    end
    checks++;
    if ((m_src ? acc_dc : acc_ic) != 3 || (m_src ? acc_ic : acc_dc) != 2) begin
      failures++; $display("FAIL stall_accepts: got ic=%0d dc=%0d want staged port 3, other 2", acc_ic, acc_dc);
    end
    l2_if.retry = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0);
      step();
      checks++;
      if (l2_if.valid !== m_v || (m_v && (l2_if.src !== m_src || l2_if.req !== m_req))) begin
        failures++;
        $display("FAIL stall_drain k=%0d: got v=%b src=%b req=%h want v=%b src=%b req=%h", k, l2_if.valid,
                 l2_if.src, l2_if.req, m_v, m_src, m_req);
      end
    end
  endtask

  task automatic test_dc_only();
    L2_arb_req_type sent[4];
    reset = 1'b1; drive(0, 0); step(); reset = 1'b0;
    l2_if.retry = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin drive(0, 1); sent[k] = dc_if.req; end
      else drive(0, 0);
      step();
      if (k >= 1 && k <= 4) begin
        checks++;
        if (l2_if.valid !== 1'b1 || l2_if.src !== 1'b1 || l2_if.req !== sent[k-1]) begin
          failures++;
          $display("FAIL dc_only k=%0d: got v=%b src=%b req=%h want v=1 src=1 req=%h", k, l2_if.valid,
                   l2_if.src, l2_if.req, sent[k-1]);
        end
      end
    end
    checks++;
    if (l2_if.valid !== 1'b0) begin failures++; $display("FAIL dc_only_idle: got v=%b want 0", l2_if.valid); end
    // Priority is untouched by uncontested grants: the first tie goes to port 0.
    drive(1, 1); step(); drive(0, 0); step();
    checks++;
    if (l2_if.valid !== 1'b1 || l2_if.src !== 1'b0) begin
      failures++; $display("FAIL tie_first: got v=%b src=%b want v=1 src=0", l2_if.valid, l2_if.src);
    end
    step();
    checks++;
    if (l2_if.valid !== 1'b1 || l2_if.src !== 1'b1) begin
      failures++; $display("FAIL tie_second: got v=%b src=%b want v=1 src=1", l2_if.valid, l2_if.src);
    end
    step();
  endtask

  task automatic test_reset_mid();
    l2_if.retry = 1'b1;
    for (int k = 0; k < 6; k++) begin drive(1, 1); step(); end
    checks++;
    if (l2_if.valid !== 1'b1 || ic_if.retry !== 1'b1 || dc_if.retry !== 1'b1) begin
      failures++; $display("FAIL rmid_setup: got v=%b icr=%b dcr=%b want 1 1 1", l2_if.valid, ic_if.retry, dc_if.retry);
    end
    reset = 1'b1;
    ic_if.valid = 1'b0; dc_if.valid = 1'b0;
    step();
    reset = 1'b0;
    l2_if.retry = 1'b0;
    checks++;
    if (l2_if.valid !== 1'b0 || ic_if.retry !== 1'b0 || dc_if.retry !== 1'b0) begin
      failures++; $display("FAIL rmid_after: got v=%b icr=%b dcr=%b want 0 0 0", l2_if.valid, ic_if.retry, dc_if.retry);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (l2_if.valid !== 1'b0) begin failures++; $display("FAIL rmid_ghost k=%0d: got v=%b want 0", k, l2_if.valid); end
    end
  endtask

  task automatic test_push_pop();
    logic [97:0] e;
    int outs = 0;
    l2_if.retry = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 14; k++) begin
      if (k < 10) begin drive(0, 1); exp_q.push_back(dc_if.req); end
      else drive(0, 0);
      step();
      checks++;
      if (dc_if.retry !== 1'b0) begin failures++; $display("FAIL pp_retry k=%0d: got %b want 0", k, dc_if.retry); end
      if (l2_if.valid === 1'b1) begin
        outs++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL pp_extra k=%0d: got req=%h want none", k, l2_if.req);
        end else begin
          e = exp_q.pop_front();
          if (l2_if.src !== 1'b1 || l2_if.req !== e) begin
            failures++; $display("FAIL pp_order k=%0d: got src=%b req=%h want src=1 req=%h", k, l2_if.src, l2_if.req, e);
          end
        end
      end
    end
    checks++;
    if (outs != 10 || exp_q.size() != 0) begin
      failures++; $display("FAIL pp_count: got outs=%0d left=%0d want 10 0", outs, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      l2_if.retry = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (l2_if.valid !== m_v || ic_if.retry !== (m_ic.size() == 2) || dc_if.retry !== (m_dc.size() == 2)) begin
        failures++;
        $display("FAIL rand_ctrl k=%0d: got v=%b icr=%b dcr=%b want v=%b icr=%b dcr=%b", k, l2_if.valid,
                 ic_if.retry, dc_if.retry, m_v, m_ic.size() == 2, m_dc.size() == 2);
      end
      if (m_v) begin
        checks++;
        if (l2_if.src !== m_src || l2_if.req !== m_req) begin
          failures++;
          $display("FAIL rand_data k=%0d: got src=%b req=%h want src=%b req=%h", k, l2_if.src, l2_if.req, m_src, m_req);
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    ic_if.valid = 1'b0; ic_if.src = 1'b0; ic_if.req = '0;
    dc_if.valid = 1'b0; dc_if.src = 1'b1; dc_if.req = '0;
    l2_if.retry = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_saturate();
    test_stall();
    test_dc_only();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
